// File: rtl/ptb_pkg.sv
// Shared constants and helpers for the packet trace buffer: vc-bit position
// and the saturating drop counter.
package ptb_pkg;

    localparam int DROP_W = 16;
    localparam logic [DROP_W-1:0] DROP_SAT = 16'hFFFF;

    function automatic int vc_bit(input int pkt_w);
        return pkt_w - 1;
    endfunction

    // Adds up to 15 simultaneous drops to the counter without wrapping past 0xFFFF.
    function automatic logic [DROP_W-1:0] drop_add(input logic [DROP_W-1:0] cur,
                                                   input logic [3:0] inc);
        logic [DROP_W:0] sum;
        sum = {1'b0, cur} + {{(DROP_W-3){1'b0}}, inc};
        if (sum > {1'b0, DROP_SAT}) begin
            return DROP_SAT;
        end else begin
            return sum[DROP_W-1:0];
        end
    endfunction

endpackage

// File: rtl/packet_trace_buffer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the priority
// pointer; the pointer moves just past the winner.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand_s;
    logic          hit_s;

    function automatic int rot(input int p, input int k);
        return (p + k) % N;
    endfunction

    // Winner search and pointer update.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand_s  = IW'(rot(int'(ptr_q), k));
            hit_s   = !gnt_any && en && req[cand_s];
            gnt_idx = hit_s ? cand_s : gnt_idx;
            gnt_any = gnt_any | hit_s;
        end
        grant[gnt_idx] = gnt_any;
        if (clr) begin
            ptr_d = '0;
        end else if (gnt_any) begin
            ptr_d = IW'(rot(int'(gnt_idx), 1));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/packet_trace_buffer.sv
// Captures filtered channel handshakes into per-channel hold registers, then
// arbitrates them into a circular trace FIFO drained over a valid/ready port.
module packet_trace_buffer
    import ptb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int PKT_W  = 64,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       ch_valid,
    input  logic [NUM_CH-1:0]       ch_ready,
    input  logic [NUM_CH*PKT_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]       cfg_ch_en,
    input  logic [1:0]              cfg_vc_mask,
    input  logic                    cfg_stop_on_full,
    input  logic                    clr,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [PKT_W-1:0]        rd_data,
    output logic [CH_W-1:0]         rd_ch,
    output logic [TS_W-1:0]         rd_ts,
    output logic [CNT_W-1:0]        count,
    output logic [DROP_W-1:0]       drop_cnt,
    output logic                    ovf
);

    localparam int VC_BIT = vc_bit(PKT_W);
    localparam int AW     = $clog2(DEPTH);
    localparam int E_W    = PKT_W + CH_W + TS_W;

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [NUM_CH-1:0] event_s, load_s, drop_s, req_s, grant_s;
    logic [PKT_W-1:0]  hold_data_a [NUM_CH];
    logic [TS_W-1:0]   hold_ts_a   [NUM_CH];
    logic [CH_W-1:0]   gnt_idx_s;
    logic              gnt_any_s, gnt_en_s;

    logic [E_W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              ovf_q, ovf_d;
    logic              full_s, pop_s, push_s, overwrite_s;
    logic [E_W-1:0]    wr_entry_s, head_ent_s;
    logic              rd_valid_q, rd_valid_d;
    logic [PKT_W-1:0]  rd_data_q, rd_data_d;
    logic [CH_W-1:0]   rd_ch_q, rd_ch_d;
    logic [TS_W-1:0]   rd_ts_q, rd_ts_d;

    // Free-running timestamp, unaffected by clr.
    always_comb begin
        ts_d = ts_q + TS_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [PKT_W-1:0] pkt_s;
        logic             hold_v_q, hold_v_d;
        logic [PKT_W-1:0] hold_data_q, hold_data_d;
        logic [TS_W-1:0]  hold_ts_q, hold_ts_d;

        assign pkt_s      = ch_data[g*PKT_W +: PKT_W];
        assign event_s[g] = ch_valid[g] & ch_ready[g] & cfg_ch_en[g] & cfg_vc_mask[pkt_s[VC_BIT]];
        // A hold being granted this cycle frees its slot for a same-cycle event.
        assign drop_s[g]  = event_s[g] & ~clr & hold_v_q & ~grant_s[g];
        assign load_s[g]  = event_s[g] & ~clr & ~drop_s[g];
        assign req_s[g]        = hold_v_q;
        assign hold_data_a[g]  = hold_data_q;
        assign hold_ts_a[g]    = hold_ts_q;

        // Hold register next state.
        always_comb begin
            hold_data_d = hold_data_q;
            hold_ts_d   = hold_ts_q;
            if (clr) begin
                hold_v_d = 1'b0;
            end else if (load_s[g]) begin
                hold_v_d    = 1'b1;
                hold_data_d = pkt_s;
                hold_ts_d   = ts_q;
            end else begin
                hold_v_d = hold_v_q & ~grant_s[g];
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hold_v_q    <= 1'b0;
                hold_data_q <= '0;
                hold_ts_q   <= '0;
            end else begin
                hold_v_q    <= hold_v_d;
                hold_data_q <= hold_data_d;
                hold_ts_q   <= hold_ts_d;
            end
        end
    end

    assign full_s   = (count_q == CNT_W'(DEPTH));
    assign gnt_en_s = ~clr & ~(full_s & cfg_stop_on_full);

    rr_arbiter #(.N(NUM_CH), .IW(CH_W)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .en      (gnt_en_s),
        .req     (req_s),
        .grant   (grant_s),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    assign pop_s       = rd_valid_q & rd_ready & ~clr;
    assign push_s      = gnt_any_s;
    assign overwrite_s = push_s & full_s & ~pop_s;
    assign wr_entry_s  = {hold_data_a[gnt_idx_s], gnt_idx_s, hold_ts_a[gnt_idx_s]};

    // FIFO pointers, occupancy, drop and overflow bookkeeping.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            drop_d  = '0;
        end else begin
            head_d  = (pop_s | overwrite_s) ? head_q + AW'(1) : head_q;
            tail_d  = push_s ? tail_q + AW'(1) : tail_q;
            if (push_s & ~pop_s & ~overwrite_s) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_s & ~push_s) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                count_d = count_q;
            end
            ovf_d  = ovf_q | overwrite_s;
            drop_d = drop_add(drop_q, 4'($countones(drop_s)));
        end
    end

    // Next head entry; bypass the write when it lands on the new head slot.
    always_comb begin
        head_ent_s = (push_s && (tail_q == head_d)) ? wr_entry_s : mem_q[head_d];
        if (clr) begin
            rd_valid_d = 1'b0;
            rd_data_d  = '0;
            rd_ch_d    = '0;
            rd_ts_d    = '0;
        end else begin
            rd_valid_d = (count_d != '0);
            {rd_data_d, rd_ch_d, rd_ts_d} = head_ent_s;
        end
    end

    // Trace storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[tail_q] <= wr_entry_s;
        end
    end

    // Control and read-port registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ch_q    <= '0;
            rd_ts_q    <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ch_q    <= rd_ch_d;
            rd_ts_q    <= rd_ts_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_ch    = rd_ch_q;
    assign rd_ts    = rd_ts_q;
    assign count    = count_q;
    assign drop_cnt = drop_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_packet_trace_buffer.sv
// Randomised and directed bench for packet_trace_buffer, checked every cycle
// against a queue-based behavioural model of the capture/trace rules.
module tb_packet_trace_buffer;

    localparam int NUM_CH = 2;
    localparam int PKT_W  = 64;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   ch_valid, ch_ready, cfg_ch_en, cfg_vc_mask;
    logic [127:0] ch_data;
    logic         cfg_stop_on_full, clr, rd_ready;
    logic         rd_valid, ovf;
    logic [63:0]  rd_data;
    logic [0:0]   rd_ch;
    logic [15:0]  rd_ts, drop_cnt;
    logic [4:0]   count;

    packet_trace_buffer #(.NUM_CH(NUM_CH), .PKT_W(PKT_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
        .cfg_ch_en(cfg_ch_en), .cfg_vc_mask(cfg_vc_mask), .cfg_stop_on_full(cfg_stop_on_full),
        .clr(clr), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_ch(rd_ch),
        .rd_ts(rd_ts), .count(count), .drop_cnt(drop_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        int          ch;
        logic [15:0] ts;
    } ent_t;

    ent_t        mq[$];
    bit          mhv   [NUM_CH];
    logic [63:0] mhd   [NUM_CH];
    logic [15:0] mhts  [NUM_CH];
    int          mptr, mdrop;
    bit          movf;
    logic [15:0] mts;
    int          tests = 0, fails = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < NUM_CH; i++) mhv[i] = 1'b0;
        mptr = 0; mdrop = 0; movf = 1'b0; mts = 16'd0;
    endtask

    // One clock edge of the trace rules, applied to the inputs present now.
    task automatic model_step();
        int          g;
        bit          ev;
        logic [63:0] pkt;
        ent_t        e;
        if (clr) begin
            model_reset_keep_ts();
            mts = mts + 16'd1;
            return;
        end
        g = -1;
        if (!(mq.size() == DEPTH && cfg_stop_on_full))
            for (int k = 0; k < NUM_CH; k++)
                if (g < 0 && mhv[(mptr + k) % NUM_CH]) g = (mptr + k) % NUM_CH;
        if (mq.size() > 0 && rd_ready) void'(mq.pop_front());
        if (g >= 0) begin
            if (mq.size() == DEPTH) begin
                void'(mq.pop_front());
                movf = 1'b1;
            end
            e.d = mhd[g]; e.ch = g; e.ts = mhts[g];
            mq.push_back(e);
            mhv[g] = 1'b0;
            mptr = (g + 1) % NUM_CH;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            pkt = ch_data[i*64 +: 64];
            ev  = ch_valid[i] && ch_ready[i] && cfg_ch_en[i] && cfg_vc_mask[pkt[63]];
            if (ev) begin
                if (mhv[i]) begin
                    if (mdrop < 65535) mdrop++;
                end else begin
                    mhv[i] = 1'b1; mhd[i] = pkt; mhts[i] = mts;
                end
            end
        end
        mts = mts + 16'd1;
    endtask

    task automatic model_reset_keep_ts();
        logic [15:0] t;
        t = mts;
        model_reset();
        mts = t;
    endtask

    task automatic idle();
        ch_valid = 2'b00; ch_ready = 2'b00; rd_ready = 1'b0; clr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic ev0(input logic [63:0] p);
        ch_valid = 2'b01; ch_ready = 2'b01; ch_data[63:0] = p;
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin
        if (chk_en && reset) begin
            chk("rd_valid", rd_valid, mq.size() > 0);
            chk("count", count, mq.size());
            chk("drop_cnt", drop_cnt, mdrop);
            chk("ovf", ovf, movf);
            if (mq.size() > 0) begin
                chk("rd_data", rd_data, mq[0].d);
                chk("rd_ch", rd_ch, mq[0].ch);
                chk("rd_ts", rd_ts, mq[0].ts);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] p, p1, pvc1;
        logic [15:0] t, t4;
        int          rd_pct;
        reset = 1'b1; ch_data = '0; cfg_ch_en = 2'b11; cfg_vc_mask = 2'b11;
        cfg_stop_on_full = 1'b0; idle();
        #1 reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset count", count, 0);
        chk("reset drop", drop_cnt, 0);
        chk("reset ovf", ovf, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset rd_ts", rd_ts, 0);
        reset = 1'b1; chk_en = 1'b1;

        // single injection at ts=5
        repeat (5) step();
        p = 64'hA5A5_0000_0000_0001;
        ev0(p); step(); idle(); step();
        chk("single rd_valid", rd_valid, 1);
        chk("single rd_data", rd_data, p);
        chk("single rd_ch", rd_ch, 0);
        chk("single rd_ts", rd_ts, 5);
        chk("single count", count, 1);
        rd_ready = 1'b1; step(); idle();
        chk("single pop count", count, 0);

        // simultaneous pair with pointer at 0
        clr = 1'b1; step(); idle();
        p = {$urandom, $urandom}; p1 = {$urandom, $urandom};
        ch_valid = 2'b11; ch_ready = 2'b11; ch_data = {p1, p};
        t = mts; step(); idle(); step(); step();
        chk("pair count", count, 2);
        chk("pair first ch", rd_ch, 0);
        chk("pair first ts", rd_ts, t);
        rd_ready = 1'b1; step(); idle();
        chk("pair second ch", rd_ch, 1);
        chk("pair second data", rd_data, p1);
        chk("pair second ts", rd_ts, t);
        rd_ready = 1'b1; step(); idle();

        // stop mode, full
        clr = 1'b1; cfg_stop_on_full = 1'b1; step(); idle();
        repeat (18) begin ev0({$urandom, $urandom}); step(); end
        idle(); repeat (2) step();
        chk("stop drop", drop_cnt, 1);
        chk("stop count", count, DEPTH);
        rd_ready = 1'b1; step(); idle(); step();
        chk("stop refill count", count, DEPTH);
        chk("stop refill drop", drop_cnt, 1);

        // wrap mode overwrite
        clr = 1'b1; cfg_stop_on_full = 1'b0; step(); idle();
        t4 = '0;
        for (int k = 1; k <= DEPTH + 3; k++) begin
            if (k == 4) t4 = mts;
            ev0({$urandom, $urandom}); step();
        end
        idle(); repeat (3) step();
        chk("wrap count", count, DEPTH);
        chk("wrap ovf", ovf, 1);
        chk("wrap head ts", rd_ts, t4);
        rd_ready = 1'b1; repeat (DEPTH) step(); idle();

        // vc and channel filters
        clr = 1'b1; step(); idle();
        cfg_vc_mask = 2'b10; cfg_ch_en = 2'b01;
        ev0({1'b0, 63'h123}); step();
        pvc1 = {1'b1, 63'h456};
        ch_valid = 2'b11; ch_ready = 2'b11; ch_data = {{1'b1, 63'h789}, pvc1}; step();
        idle(); repeat (2) step();
        chk("filter count", count, 1);
        chk("filter data", rd_data, pvc1);
        chk("filter drop", drop_cnt, 0);
        cfg_vc_mask = 2'b11; cfg_ch_en = 2'b11;

        // clr flush with count 3, drop 2
        clr = 1'b1; step(); idle();
        repeat (3) begin
            ch_valid = 2'b11; ch_ready = 2'b11; ch_data = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        idle(); repeat (2) step();
        rd_ready = 1'b1; step(); idle();
        chk("preclr count", count, 3);
        chk("preclr drop", drop_cnt, 2);
        clr = 1'b1; step(); idle();
        chk("clr count", count, 0);
        chk("clr drop", drop_cnt, 0);

        // async reset mid-burst
        repeat (6) begin ev0({$urandom, $urandom}); step(); end
        chk("burst count", count, 5);
        @(posedge clk); model_step();
        #2 reset = 1'b0;
        #1;
        chk("areset rd_valid", rd_valid, 0);
        chk("areset count", count, 0);
        chk("areset rd_data", rd_data, 0);
        chk("areset drop", drop_cnt, 0);
        chk("areset ovf", ovf, 0);
        model_reset();
        @(negedge clk); reset = 1'b1; idle();

        // random traffic
        rd_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 300 == 0) begin
                cfg_ch_en        = 2'($urandom_range(1, 3));
                cfg_vc_mask      = 2'($urandom_range(1, 3));
                cfg_stop_on_full = 1'($urandom_range(0, 1));
                rd_pct           = $urandom_range(0, 2) * 45 + 5;
            end
            ch_valid = 2'($urandom);
            ch_ready = 2'($urandom);
            ch_data  = {$urandom, $urandom, $urandom, $urandom};
            rd_ready = ($urandom_range(0, 99) < rd_pct);
            clr      = ($urandom_range(0, 199) == 0);
            step();
        end
        idle(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
